// File: rtl/sub_pkg.sv
// Shared defaults and FSM state encoding for the subtractor arbiter slice.
package sub_pkg;

   localparam int WIDTH_DEF   = 15;
   localparam int TIMEOUT_DEF = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } sub_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: the first requester at or after last_grant+1 (mod N_REQ) wins.
module rr_arbiter
   import sub_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last_grant,
   output logic [N_REQ-1:0] gnt
);

   logic [IW-1:0] idx;

   // Walk from the farthest slot to the nearest; the nearest requester is written last and wins.
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = IW'((int'(last_grant) + k) % N_REQ);
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sub_arbiter.sv
// Shares one external subtractor among N_REQ requesters, one operation in flight at a time.
//   state | meaning
//   IDLE  | waiting for any REQ_VALID; grant, latch operands
//   ISSUE | SUB_DE pulse with latched operands, clear timeout counter
//   WAIT  | waiting for SUB_OE, bounded by TIMEOUT cycles
//   RESP  | RSP_VALID to owner until its RSP_READY
module sub_arbiter
   import sub_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int WIDTH   = WIDTH_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [N_REQ-1:0]       REQ_VALID,
   output logic [N_REQ-1:0]       REQ_READY,
   input  logic [N_REQ*WIDTH-1:0] REQ_X,
   input  logic [N_REQ*WIDTH-1:0] REQ_Y,
   input  logic [N_REQ-1:0]       REQ_BIN,
   output logic [N_REQ-1:0]       RSP_VALID,
   input  logic [N_REQ-1:0]       RSP_READY,
   output logic [WIDTH-1:0]       RSP_DIFF,
   output logic                   RSP_BOUT,
   output logic                   RSP_ERR,
   output logic                   SUB_DE,
   output logic [WIDTH-1:0]       SUB_X,
   output logic [WIDTH-1:0]       SUB_Y,
   output logic                   SUB_BIN,
   input  logic                   SUB_OE,
   input  logic [WIDTH-1:0]       SUB_DIFF,
   input  logic                   SUB_BOUT
);

   localparam int            IW       = $clog2(N_REQ);
   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);
   localparam logic [CW-1:0] CNT_TC   = CW'(TIMEOUT - 1);

   sub_state_t       state, state_nx;
   logic [IW-1:0]    last_grant, gnt_idx;
   logic [N_REQ-1:0] gnt, owner;
   logic [CW-1:0]    wait_cnt;
   logic             wait_tc, any_req;
   logic [WIDTH-1:0] sel_x, sel_y;
   logic             sel_bin;

   rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
      .req        (REQ_VALID),
      .last_grant (last_grant),
      .gnt        (gnt)
   );

   assign any_req = |REQ_VALID;
   assign wait_tc = (wait_cnt == CNT_TC);

   always_comb begin
      sel_x   = '0;
      sel_y   = '0;
      sel_bin = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            sel_x   = REQ_X[i*WIDTH +: WIDTH];
            sel_y   = REQ_Y[i*WIDTH +: WIDTH];
            sel_bin = REQ_BIN[i];
            gnt_idx = IW'(i);
         end
      end
   end

   always_comb begin
      state_nx  = state;
      REQ_READY = '0;
      RSP_VALID = '0;
      SUB_DE    = 1'b0;
      case (state)
         IDLE: begin
            REQ_READY = RST ? '0 : gnt;
            if (any_req) state_nx = ISSUE;
         end
         ISSUE: begin
            SUB_DE   = 1'b1;
            state_nx = WAIT;
         end
         WAIT: begin
            // OE on the terminal-count cycle is still a success.
            if (SUB_OE || wait_tc) state_nx = RESP;
         end
         RESP: begin
            RSP_VALID = owner;
            if (|(RSP_READY & owner)) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         last_grant <= LAST_RST;
         owner      <= '0;
         wait_cnt   <= '0;
         SUB_X      <= '0;
         SUB_Y      <= '0;
         SUB_BIN    <= 1'b0;
         RSP_DIFF   <= '0;
         RSP_BOUT   <= 1'b0;
         RSP_ERR    <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner      <= gnt;
                  last_grant <= gnt_idx;
                  SUB_X      <= sel_x;
                  SUB_Y      <= sel_y;
                  SUB_BIN    <= sel_bin;
               end
            end
            ISSUE: wait_cnt <= '0;
            WAIT: begin
               if (SUB_OE) begin
                  RSP_DIFF <= SUB_DIFF;
                  RSP_BOUT <= SUB_BOUT;
                  RSP_ERR  <= 1'b0;
               end else if (wait_tc) begin
                  RSP_DIFF <= '0;
                  RSP_BOUT <= 1'b0;
                  RSP_ERR  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sub_arbiter.sv
// Scoreboarded bench for sub_arbiter with a behavioural subtractor of programmable latency.
module tb_sub_arbiter;

   localparam int N  = 4;
   localparam int W  = 15;
   localparam int TO = 15;

   typedef struct packed {
      logic [N-1:0] valid;
      logic [W-1:0] diff;
      logic         bout;
      logic         err;
   } rsp_t;

   logic           CLK = 1'b0;
   logic           RST;
   logic [N-1:0]   REQ_VALID, REQ_READY, REQ_BIN, RSP_VALID, RSP_READY;
   logic [N*W-1:0] REQ_X, REQ_Y;
   logic [W-1:0]   RSP_DIFF, SUB_X, SUB_Y, SUB_DIFF;
   logic           RSP_BOUT, RSP_ERR, SUB_DE, SUB_BIN, SUB_OE, SUB_BOUT;

   logic           m_oe, f_oe, m_bout;
   logic [W-1:0]   m_diff;
   logic [W:0]     m_t;
   int             m_l;
   int             lat_cfg;
   int             n_cmp = 0;
   int             n_bad = 0;
   rsp_t           sb[$];
   logic [N-1:0]   g;
   int             fair_diff[4] = '{999, 1998, 2997, 3996};

   assign SUB_OE   = m_oe | f_oe;
   assign SUB_DIFF = m_diff;
   assign SUB_BOUT = m_bout;

   always #5 CLK = ~CLK;

   sub_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .REQ_VALID (REQ_VALID),
      .REQ_READY (REQ_READY),
      .REQ_X     (REQ_X),
      .REQ_Y     (REQ_Y),
      .REQ_BIN   (REQ_BIN),
      .RSP_VALID (RSP_VALID),
      .RSP_READY (RSP_READY),
      .RSP_DIFF  (RSP_DIFF),
      .RSP_BOUT  (RSP_BOUT),
      .RSP_ERR   (RSP_ERR),
      .SUB_DE    (SUB_DE),
      .SUB_X     (SUB_X),
      .SUB_Y     (SUB_Y),
      .SUB_BIN   (SUB_BIN),
      .SUB_OE    (SUB_OE),
      .SUB_DIFF  (SUB_DIFF),
      .SUB_BOUT  (SUB_BOUT)
   );

   function automatic rsp_t mk(input logic [N-1:0] v, input logic [W-1:0] d,
                               input logic bo, input logic er);
      rsp_t r;
      r.valid = v;
      r.diff  = d;
      r.bout  = bo;
      r.err   = er;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_ops(input int i, input logic [W-1:0] x, input logic [W-1:0] y, input logic b);
      REQ_X[i*W +: W] = x;
      REQ_Y[i*W +: W] = y;
      REQ_BIN[i]      = b;
   endtask

   task automatic wait_grant(output logic [N-1:0] gg);
      gg = '0;
      for (int n = 0; n < 100; n++) begin
         @(negedge CLK);
         if (REQ_READY != '0) begin
            gg = REQ_READY;
            return;
         end
      end
      n_cmp++;
      n_bad++;
      $display("FAIL grant_timeout: got no REQ_READY, expected one within 100 cycles");
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 200; n++) begin
         if (sb.size() == 0) return;
         @(negedge CLK);
      end
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", sb.size());
   endtask

   task automatic run_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y, input logic b,
                         input rsp_t e, input int lat, input int exp_lat);
      logic [N-1:0] gg;
      int           n;
      lat_cfg = lat;
      set_ops(i, x, y, b);
      sb.push_back(e);
      @(posedge CLK);
      #1 REQ_VALID = N'(1 << i);
      wait_grant(gg);
      chk("grant", 32'(gg), 32'(1 << i));
      @(posedge CLK);
      #1 REQ_VALID = '0;
      @(negedge CLK);
      chk("sub_de", 32'(SUB_DE), 1);
      chk("sub_x", 32'(SUB_X), 32'(x));
      chk("sub_y", 32'(SUB_Y), 32'(y));
      chk("sub_bin", 32'(SUB_BIN), 32'(b));
      n = 0;
      while (RSP_VALID == '0 && n < 60) begin
         @(negedge CLK);
         n++;
      end
      chk("rsp_latency", n, exp_lat);
   endtask

   // Subtractor model: raises OE in the lat-th WAIT cycle after seeing SUB_DE; lat 0 never answers.
   initial begin
      m_oe   = 1'b0;
      m_diff = '0;
      m_bout = 1'b0;
      forever begin
         @(negedge CLK);
         if (SUB_DE && lat_cfg > 0) begin
            m_t = {1'b0, SUB_X} - {1'b0, SUB_Y} - {{W{1'b0}}, SUB_BIN};
            m_l = lat_cfg;
            repeat (m_l) @(posedge CLK);
            #1;
            m_oe   = 1'b1;
            m_diff = m_t[W-1:0];
            m_bout = m_t[W];
            @(posedge CLK);
            #1 m_oe = 1'b0;
         end
      end
   end

   initial begin
      rsp_t e;
      forever begin
         @(negedge CLK);
         if (!RST && (RSP_VALID & RSP_READY) != '0) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL rsp_unexpected: got valid=%b diff=%0d, expected no response",
                        RSP_VALID, RSP_DIFF);
            end else begin
               e = sb.pop_front();
               if ({RSP_VALID, RSP_DIFF, RSP_BOUT, RSP_ERR} !== e) begin
                  n_bad++;
                  $display("FAIL rsp: got valid=%b diff=%0d bout=%b err=%b expected valid=%b diff=%0d bout=%b err=%b",
                           RSP_VALID, RSP_DIFF, RSP_BOUT, RSP_ERR, e.valid, e.diff, e.bout, e.err);
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no end of test, expected completion within 300000 time units");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RST = 1'b1; REQ_VALID = '0; REQ_X = '0; REQ_Y = '0; REQ_BIN = '0;
      RSP_READY = '0; f_oe = 1'b0; lat_cfg = 1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_req_ready", 32'(REQ_READY), 0);
      chk("rst_rsp_valid", 32'(RSP_VALID), 0);
      chk("rst_sub_de", 32'(SUB_DE), 0);
      chk("rst_sub_x", 32'(SUB_X), 0);
      chk("rst_rsp_diff", 32'(RSP_DIFF), 0);
      chk("rst_rsp_err", 32'(RSP_ERR), 0);
      @(posedge CLK);
      #1 RST = 1'b0;
      RSP_READY = '1;

      // Fairness: everyone asks continuously for eight operations.
      lat_cfg = 1;
      for (int i = 0; i < N; i++) set_ops(i, W'(1000 * (i + 1)), W'(i + 1), 1'b0);
      for (int k = 0; k < 8; k++) sb.push_back(mk(N'(1 << (k % N)), W'(fair_diff[k % N]), 1'b0, 1'b0));
      REQ_VALID = '1;
      for (int k = 0; k < 8; k++) begin
         wait_grant(g);
         chk("fair_grant", 32'(g), 32'(1 << (k % N)));
      end
      @(posedge CLK);
      #1 REQ_VALID = '0;
      wait_drain();
      repeat (3) @(posedge CLK);

      run_op(0, 40, 12, 1'b0, mk(4'b0001, 28, 1'b0, 1'b0), 1, 2);
      wait_drain();
      run_op(1, 5, 9, 1'b1, mk(4'b0010, 32763, 1'b1, 1'b0), 2, 3);
      wait_drain();
      run_op(1, 7, 3, 1'b0, mk(4'b0010, 0, 1'b0, 1'b1), 0, TO + 1);
      wait_drain();
      run_op(2, 300, 45, 1'b0, mk(4'b0100, 255, 1'b0, 1'b0), TO, TO + 1);
      wait_drain();
      run_op(3, 50, 10, 1'b0, mk(4'b1000, 0, 1'b0, 1'b1), TO + 1, TO + 1);
      wait_drain();
      repeat (20) @(posedge CLK);

      // Backpressure: owner holds off while the others assert ready and request.
      RSP_READY = 4'b0111;
      run_op(3, 20, 20, 1'b1, mk(4'b1000, 32767, 1'b1, 1'b0), 1, 2);
      REQ_VALID = 4'b0111;
      repeat (5) begin
         @(negedge CLK);
         chk("bp_valid", 32'(RSP_VALID), 32'h8);
         chk("bp_diff", 32'(RSP_DIFF), 32767);
         chk("bp_bout", 32'(RSP_BOUT), 1);
         chk("bp_req_ready", 32'(REQ_READY), 0);
      end
      @(posedge CLK);
      #1 REQ_VALID = '0;
      RSP_READY = '1;
      wait_drain();
      repeat (3) @(posedge CLK);

      // Reset while waiting on a subtractor that never answers, then a stray OE.
      lat_cfg = 0;
      set_ops(2, 9, 1, 1'b0);
      #1 REQ_VALID = 4'b0100;
      wait_grant(g);
      chk("abort_grant", 32'(g), 32'h4);
      @(posedge CLK);
      #1 REQ_VALID = '0;
      @(negedge CLK);
      chk("abort_de", 32'(SUB_DE), 1);
      repeat (3) @(posedge CLK);
      #1 RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("abort_rsp_valid", 32'(RSP_VALID), 0);
      chk("abort_req_ready", 32'(REQ_READY), 0);
      chk("abort_sub_de", 32'(SUB_DE), 0);
      chk("abort_sub_x", 32'(SUB_X), 0);
      chk("abort_sub_y", 32'(SUB_Y), 0);
      chk("abort_sub_bin", 32'(SUB_BIN), 0);
      chk("abort_rsp_diff", 32'(RSP_DIFF), 0);
      chk("abort_rsp_bout", 32'(RSP_BOUT), 0);
      chk("abort_rsp_err", 32'(RSP_ERR), 0);
      @(posedge CLK);
      #1 f_oe = 1'b1;
      @(posedge CLK);
      #1 f_oe = 1'b0;
      repeat (4) begin
         @(negedge CLK);
         chk("abort_no_rsp", 32'(RSP_VALID), 0);
      end

      lat_cfg = 1;
      set_ops(0, 40, 12, 1'b0);
      sb.push_back(mk(4'b0001, 28, 1'b0, 1'b0));
      @(posedge CLK);
      #1 REQ_VALID = '1;
      wait_grant(g);
      chk("post_rst_grant", 32'(g), 32'h1);
      @(posedge CLK);
      #1 REQ_VALID = '0;
      wait_drain();
      repeat (3) @(posedge CLK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
